vscpu_loader: RTL and testbench

Program loader and RAM-port owner sitting between the byte-stream receiver and the VSCPU/RAM pair. After reset, or on request, it holds the CPU in reset. It then takes a length-prefixed program image from an 8-bit valid/ready stream and writes it word-by-word into RAM from address 0. When the image is complete it releases the CPU and passes the CPU's RAM port straight through to the RAM.

---
 rtl/vscpu_pkg.sv | 17 +
 rtl/vscpu_word_packer.sv | 30 +++
 rtl/vscpu_loader.sv | 139 +++++++++++++
 tb/tb_vscpu_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared types and constants for the VSCPU program loader.
package vscpu_pkg;

    localparam int unsigned SizeDefault = 14;
    // Image header: little-endian word count
    localparam int unsigned HdrBytes = 2;

    typedef enum logic [2:0] {
        StLen0,
        StLen1,
        StByte,
        StWrite,
        StRelease,
        StRun
    } load_state_e;

endpackage

// File: rtl/vscpu_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word.
module vscpu_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            // Shift right so byte 0 ends up in bits 7:0 after four loads
            word_q <= {byte_in, word_q[31:8]};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word      = word_q;
    // High when the byte being loaded this cycle completes the word
    assign word_full = load && (idx_q == 2'd3);

endmodule

// File: rtl/vscpu_loader.sv
// Holds the CPU in reset, streams a length-prefixed image into RAM, then hands
// the RAM port to the CPU.
module vscpu_loader
    import vscpu_pkg::*;
#(
    parameter int unsigned SIZE = SizeDefault
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            load_req,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data_to,
    output logic [31:0]     cpu_data_from,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data_to,
    input  logic [31:0]     ram_data_from,
    output logic            done,
    output logic            len_err
);

    localparam int unsigned CntW     = SIZE + 1;
    localparam int unsigned HdrW     = 8 * HdrBytes;
    localparam logic [31:0] MaxWords = 32'(1) << SIZE;

    load_state_e     state_q;
    logic [SIZE-1:0] addr_q;
    logic [CntW-1:0] n_eff_q;
    logic [7:0]      len_lo_q;
    logic            done_q;
    logic            len_err_q;

    logic            accept;
    logic            run;
    logic [HdrW-1:0] hdr_n;
    logic            hdr_big;
    logic            last_word;
    logic [31:0]     packed_word;
    logic            word_full;

    assign in_ready  = !rst && (state_q inside {StLen0, StLen1, StByte});
    assign accept    = in_valid && in_ready;
    assign run       = (state_q == StRun) && !rst;
    assign hdr_n     = {in_data, len_lo_q};
    assign hdr_big   = 32'(hdr_n) > MaxWords;
    assign last_word = ({1'b0, addr_q} == (n_eff_q - CntW'(1)));

    vscpu_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept && (state_q == StLen1)),
        .load      (accept && (state_q == StByte)),
        .byte_in   (in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLen0;
            addr_q    <= '0;
            n_eff_q   <= '0;
            len_lo_q  <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StLen0: begin
                    if (accept) begin
                        len_lo_q <= in_data;
                        state_q  <= StLen1;
                    end
                end
                StLen1: begin
                    if (accept) begin
                        addr_q <= '0;
                        // Clamp to RAM depth; excess image bytes are left unconsumed
                        if (hdr_big) begin
                            len_err_q <= 1'b1;
                            n_eff_q   <= CntW'(MaxWords);
                        end else begin
                            n_eff_q <= CntW'(hdr_n);
                        end
                        state_q <= (hdr_n == '0) ? StRelease : StByte;
                    end
                end
                StByte: begin
                    if (word_full) state_q <= StWrite;
                end
                StWrite: begin
                    if (last_word) begin
                        state_q <= StRelease;
                    end else begin
                        addr_q  <= addr_q + SIZE'(1);
                        state_q <= StByte;
                    end
                end
                StRelease: begin
                    state_q <= StRun;
                    done_q  <= 1'b1;
                end
                StRun: begin
                    if (load_req) begin
                        state_q   <= StLen0;
                        len_err_q <= 1'b0;
                    end
                end
                default: state_q <= StLen0;
            endcase
        end
    end

    always_comb begin
        ram_wrEn      = 1'b0;
        ram_addr      = addr_q;
        ram_data_to   = '0;
        cpu_data_from = '0;
        if (run) begin
            ram_wrEn      = cpu_wrEn;
            ram_addr      = cpu_addr;
            ram_data_to   = cpu_data_to;
            cpu_data_from = ram_data_from;
        end else if ((state_q == StWrite) && !rst) begin
            ram_wrEn    = 1'b1;
            ram_data_to = packed_word;
        end
    end

    assign cpu_rst = !run;
    assign done    = done_q;
    assign len_err = len_err_q;

endmodule

// File: tb/tb_vscpu_loader.sv
// Randomized bench for vscpu_loader: images are decoded by a byte-level model and
// compared against observed RAM writes, handover timing and port ownership.
module tb_vscpu_loader;
    import vscpu_pkg::*;

    localparam int unsigned SA = SizeDefault;
    localparam int unsigned SB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, in_valid = 1'b0, load_req = 1'b0, sel = 1'b0;
    logic [7:0]    in_data = '0;
    logic          cpu_wrEn = 1'b0;
    logic [SA-1:0] cpu_addr = '0;
    logic [31:0]   cpu_data_to = '0, ram_data_from = '0;

    logic          rdy_a, crst_a, wr_a, done_a, err_a;
    logic [SA-1:0] addr_a;
    logic [31:0]   dto_a, cfrom_a;
    logic          rdy_b, crst_b, wr_b, done_b, err_b;
    logic [SB-1:0] addr_b;
    logic [31:0]   dto_b, cfrom_b;

    vscpu_loader #(.SIZE(SA)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_data(in_data),
        .in_ready(rdy_a), .load_req(load_req & ~sel), .cpu_rst(crst_a),
        .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data_to(cpu_data_to),
        .cpu_data_from(cfrom_a), .ram_wrEn(wr_a), .ram_addr(addr_a),
        .ram_data_to(dto_a), .ram_data_from(ram_data_from), .done(done_a), .len_err(err_a)
    );

    vscpu_loader #(.SIZE(SB)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_data(in_data),
        .in_ready(rdy_b), .load_req(load_req & sel), .cpu_rst(crst_b),
        .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr[SB-1:0]), .cpu_data_to(cpu_data_to),
        .cpu_data_from(cfrom_b), .ram_wrEn(wr_b), .ram_addr(addr_b),
        .ram_data_to(dto_b), .ram_data_from(ram_data_from), .done(done_b), .len_err(err_b)
    );

    // Observe whichever loader is selected
    logic          mon_rdy, mon_cpu_rst, mon_wr, mon_done, mon_len_err;
    logic [SA-1:0] mon_addr;
    logic [31:0]   mon_dto, mon_cfrom;
    assign mon_rdy     = sel ? rdy_b : rdy_a;
    assign mon_cpu_rst = sel ? crst_b : crst_a;
    assign mon_wr      = sel ? wr_b : wr_a;
    assign mon_done    = sel ? done_b : done_a;
    assign mon_len_err = sel ? err_b : err_a;
    assign mon_addr    = sel ? SA'(addr_b) : addr_a;
    assign mon_dto     = sel ? dto_b : dto_a;
    assign mon_cfrom   = sel ? cfrom_b : cfrom_a;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_addr[$], got_data[$];
    int unsigned done_cnt, rdy_in_write, rdy_in_run, port_leak, run_cycles;
    int unsigned last_wr_cyc, rel_cyc, last_acc_cyc;
    logic        prev_cpu_rst = 1'b1;

    always @(negedge clk) begin
        if (!rst && mon_cpu_rst && mon_wr) begin
            got_addr.push_back(32'(mon_addr));
            got_data.push_back(mon_dto);
            last_wr_cyc = cyc;
            if (mon_rdy) rdy_in_write++;
        end
        if (!rst && !mon_cpu_rst) begin
            run_cycles++;
            if (mon_rdy) rdy_in_run++;
        end
        if (mon_cpu_rst && !mon_wr && (mon_dto != 0 || mon_cfrom != 0)) port_leak++;
        if (mon_done) done_cnt++;
        if (prev_cpu_rst && !mon_cpu_rst) rel_cyc = cyc;
        prev_cpu_rst = mon_cpu_rst;
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0; rdy_in_write = 0; rdy_in_run = 0; port_leak = 0; run_cycles = 0;
        last_wr_cyc = 0; rel_cyc = 0; last_acc_cyc = 0;
    endtask

    // Reference model: decode the image by its format rules
    logic [7:0]  img[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic        exp_err;

    task automatic build_expect(input int unsigned s);
        int unsigned n, lim, neff;
        n    = {img[1], img[0]};
        lim  = 1 << s;
        neff = (n > lim) ? lim : n;
        exp_err = (n > lim);
        exp_addr.delete();
        exp_data.delete();
        for (int unsigned k = 0; k < neff; k++) begin
            exp_addr.push_back(k);
            exp_data.push_back({img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]});
        end
    endtask

    task automatic make_image(input int unsigned n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        for (int unsigned i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!mon_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!mon_rdy) check("stall", 64'(mon_rdy), 64'd1);
        else begin
            last_acc_cyc = cyc;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        @(negedge clk);
        while (mon_cpu_rst && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (mon_cpu_rst) check({tag, ":release"}, 64'(mon_cpu_rst), 64'd0);
        repeat (3) @(negedge clk);
        step();
    endtask

    task automatic load_and_check(input string tag, input int unsigned gap_max);
        build_expect(sel ? SB : SA);
        mon_clear();
        cpu_wrEn      = 1'b1;
        cpu_addr      = SA'($urandom);
        cpu_data_to   = $urandom;
        ram_data_from = $urandom | 32'h1;
        foreach (img[i]) send_byte(img[i], $urandom_range(gap_max, 0));
        wait_release(tag);
        check({tag, ":nwr"}, got_addr.size(), exp_addr.size());
        foreach (exp_addr[i]) begin
            if (i < got_addr.size()) begin
                check($sformatf("%s:a%0d", tag, i), got_addr[i], exp_addr[i]);
                check($sformatf("%s:d%0d", tag, i), got_data[i], exp_data[i]);
            end
        end
        check({tag, ":done"}, done_cnt, 1);
        check({tag, ":len_err"}, 64'(mon_len_err), 64'(exp_err));
        if (exp_addr.size() > 0) check({tag, ":rel_lat"}, rel_cyc - last_wr_cyc, 2);
        else check({tag, ":rel_lat0"}, rel_cyc - last_acc_cyc, 2);
        check({tag, ":rdy_wr"}, rdy_in_write, 0);
        check({tag, ":rdy_run"}, rdy_in_run, 0);
        check({tag, ":leak"}, port_leak, 0);
    endtask

    task automatic pulse_load_req(input string tag);
        cpu_wrEn    = 1'b1;
        cpu_addr    = SA'(9);
        cpu_data_to = 32'hC0FF_EE00 | $urandom_range(255, 0);
        load_req    = 1'b1;
        @(negedge clk);
        check({tag, ":lr_wr"}, 64'(mon_wr), 64'd1);
        check({tag, ":lr_addr"}, 64'(mon_addr), 64'd9);
        check({tag, ":lr_dto"}, mon_dto, cpu_data_to);
        @(posedge clk);
        #1 load_req = 1'b0;
        @(negedge clk);
        check({tag, ":lr_crst"}, 64'(mon_cpu_rst), 64'd1);
        check({tag, ":lr_err"}, 64'(mon_len_err), 64'd0);
        check({tag, ":lr_rdy"}, 64'(mon_rdy), 64'd1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        mon_clear();
        // Reset state with live CPU inputs that must not leak through
        cpu_wrEn      = 1'b1;
        cpu_data_to   = 32'hDEAD_0001;
        ram_data_from = 32'hFFFF_FFFF;
        repeat (2) step();
        @(negedge clk);
        check("rst:rdy", 64'(mon_rdy), 64'd0);
        check("rst:crst", 64'(mon_cpu_rst), 64'd1);
        check("rst:wr", 64'(mon_wr), 64'd0);
        check("rst:done", 64'(mon_done), 64'd0);
        check("rst:err", 64'(mon_len_err), 64'd0);
        check("rst:cfrom", mon_cfrom, 64'd0);
        check("rst:dto", mon_dto, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst:rdy_after", 64'(mon_rdy), 64'd1);
        check("rst:crst_after", 64'(mon_cpu_rst), 64'd1);
        step();

        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_and_check("two", 0);

        pulse_load_req("empty");
        img = '{8'h00, 8'h00};
        load_and_check("empty", 0);

        pulse_load_req("gaps");
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_and_check("gaps", 3);

        // Pass-through in RUN
        cpu_wrEn = 1'b1; cpu_addr = SA'(5); cpu_data_to = 32'hA5; ram_data_from = 32'h1234;
        #1;
        check("pt:wr", 64'(mon_wr), 64'd1);
        check("pt:addr", 64'(mon_addr), 64'd5);
        check("pt:dto", mon_dto, 64'hA5);
        check("pt:cfrom", mon_cfrom, 64'h1234);
        step();
        for (int i = 0; i < 4; i++) begin
            cpu_wrEn = 1'($urandom); cpu_addr = SA'($urandom);
            cpu_data_to = $urandom; ram_data_from = $urandom;
            #1;
            check($sformatf("ptr%0d:wr", i), 64'(mon_wr), 64'(cpu_wrEn));
            check($sformatf("ptr%0d:addr", i), 64'(mon_addr), 64'(cpu_addr));
            check($sformatf("ptr%0d:dto", i), mon_dto, cpu_data_to);
            check($sformatf("ptr%0d:cfrom", i), mon_cfrom, ram_data_from);
            step();
        end

        // Reset mid-word: nothing written, CPU stays in reset
        pulse_load_req("abort");
        mon_clear();
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (img[i]) send_byte(img[i], 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort:rdy", 64'(mon_rdy), 64'd1);
        check("abort:crst", 64'(mon_cpu_rst), 64'd1);
        check("abort:nwr", got_addr.size(), 0);
        check("abort:run", run_cycles, 0);
        step();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_and_check("after_abort", 0);

        for (int t = 0; t < 4; t++) begin
            pulse_load_req($sformatf("rnd%0d", t));
            make_image($urandom_range(6, 1));
            load_and_check($sformatf("rnd%0d", t), $urandom_range(3, 0));
        end

        // Oversized header on the small instance
        sel = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        img.delete();
        img.push_back(8'hFF);
        img.push_back(8'hFF);
        for (int i = 0; i < 64; i++) img.push_back(8'($urandom));
        load_and_check("big", 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (5) step();
        in_valid = 1'b0;
        @(negedge clk);
        check("big:rdy_after", rdy_in_run, 0);
        check("big:err_sticky", 64'(mon_len_err), 64'd1);
        step();

        pulse_load_req("reload_b");
        make_image(3);
        load_and_check("reload_b", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
